emmc_host_arbiter: RTL

// - Shares the single eMMC host-SM transaction port (host_ready/host_start/host_we/host_wr_dat) between N_REQ clients.
// - Round-robin arbitration; one transaction is in flight at a time.
// - Sequences the handshake start -> ack (ready low) -> done (ready high), with a watchdog timeout.
// - Sits between DMA/CPU-side clients and the eMMC host state machine; replaces the fixed test driver in system builds.

---
 rtl/emmc_arb_pkg.sv | 26 ++
 rtl/emmc_rr_pick.sv | 35 +++
 rtl/emmc_host_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/emmc_arb_pkg.sv
// Shared types and helpers for the eMMC host-port arbiter.
// Holds the FSM state encoding, default sizing and the round-robin pointer step.
package emmc_arb_pkg;

    localparam int N_REQ_DEF       = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        if (ptr + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/emmc_rr_pick.sv
// Rotating priority encoder: first valid requester at or above ptr_i, wrapping.
// Purely combinational; the caller registers whatever it needs.
module emmc_rr_pick
    import emmc_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [PTR_W-1:0] win_idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] idx_s;
    logic             hit_s;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s           = PTR_W'((int'(ptr_i) + k) % N_REQ);
            hit_s           = !any_o && valid_i[idx_s];
            win_oh_o[idx_s] = hit_s;
            win_idx_o       = hit_s ? idx_s : win_idx_o;
            any_o           = any_o | hit_s;
        end
    end

endmodule

// File: rtl/emmc_host_arbiter.sv
// Round-robin arbiter sharing one eMMC host-SM transaction port among N_REQ clients.
// One transaction in flight; start -> ack (ready low) -> done (ready high), with watchdog.
module emmc_host_arbiter
    import emmc_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdat_i,
    output logic [N_REQ-1:0]        req_gnt_o,
    output logic [N_REQ-1:0]        req_done_o,
    output logic                    rsp_err_o,
    output logic [DATA_W-1:0]       rsp_rdat_o,
    input  logic                    host_ready_i,
    output logic                    host_start_o,
    output logic                    host_we_o,
    output logic [ADDR_W-1:0]       host_addr_o,
    output logic [DATA_W-1:0]       host_wr_dat_o,
    input  logic [DATA_W-1:0]       host_rd_dat_i
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic            WD_EN   = (TIMEOUT_CYC != 0);

    state_e             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   win_idx_q;
    logic [N_REQ-1:0]   win_oh_q;
    logic [WD_W-1:0]    wd_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               err_q;
    logic               start_q;
    logic               host_we_q;
    logic [ADDR_W-1:0]  host_addr_q;
    logic [DATA_W-1:0]  host_wdat_q;
    logic [DATA_W-1:0]  rsp_rdat_q;

    logic [N_REQ-1:0]   win_oh_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic               any_s;
    logic               sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdat_s;
    logic               wd_expired_s;

    emmc_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid_i   (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .any_o     (any_s)
    );

    // One-hot mux of the winning client's request fields.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_wdat_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_we_s   = sel_we_s | (win_oh_s[k] & req_we_i[k]);
            sel_addr_s = sel_addr_s | ({ADDR_W{win_oh_s[k]}} & req_addr_i[k*ADDR_W +: ADDR_W]);
            sel_wdat_s = sel_wdat_s | ({DATA_W{win_oh_s[k]}} & req_wdat_i[k*DATA_W +: DATA_W]);
        end
    end

    assign wd_expired_s = WD_EN && (wd_q == WD_LAST);

    // Transaction FSM with latched request, watchdog and rotation pointer.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            win_oh_q    <= '0;
            wd_q        <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            host_we_q   <= 1'b0;
            host_addr_q <= '0;
            host_wdat_q <= '0;
            rsp_rdat_q  <= '0;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_s && host_ready_i) begin
                        gnt_q       <= win_oh_s;
                        win_oh_q    <= win_oh_s;
                        win_idx_q   <= win_idx_s;
                        host_we_q   <= sel_we_s;
                        host_addr_q <= sel_addr_s;
                        host_wdat_q <= sel_wdat_s;
                        state_q     <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    wd_q    <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!host_ready_i) begin
                        wd_q    <= '0;
                        state_q <= WAIT_DONE;
                    end else if (wd_expired_s) begin
                        done_q  <= win_oh_q;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (host_ready_i) begin
                        done_q  <= win_oh_q;
                        state_q <= RESP;
                        if (!host_we_q) begin
                            rsp_rdat_q <= host_rd_dat_i;
                        end else begin
                            rsp_rdat_q <= rsp_rdat_q;
                        end
                    end else if (wd_expired_s) begin
                        done_q  <= win_oh_q;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                RESP: begin
                    rr_ptr_q <= PTR_W'(rr_next(32'(win_idx_q), N_REQ));
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_gnt_o     = gnt_q;
    assign req_done_o    = done_q;
    assign rsp_err_o     = err_q;
    assign rsp_rdat_o    = rsp_rdat_q;
    assign host_start_o  = start_q;
    assign host_we_o     = host_we_q;
    assign host_addr_o   = host_addr_q;
    assign host_wr_dat_o = host_wdat_q;

endmodule
